serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// computed as a + ~b + 1 through a single registered full-adder slice.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 6
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  // Full-adder slice on the current LSBs with the subtrahend inverted.
  logic             nb;
  logic             s;
  logic             c_nxt;
  logic [WIDTH-1:0] sr_nxt;

  assign nb     = ~sb_q[0];
  assign s      = sa_q[0] ^ nb ^ c_q;
  assign c_nxt  = (sa_q[0] & nb) | (sa_q[0] & c_q) | (nb & c_q);
  assign sr_nxt = {s, sr_q[WIDTH-1:1]};

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: capture in IDLE, one bit per RUN edge, publish results on the last bit.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          c_d     = 1'b1;  // the +1 of the two's-complement negation
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = c_nxt;
        sr_d  = sr_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = StDone;
          diff_d   = sr_nxt;
          borrow_d = ~c_nxt;
          zero_d   = (sr_nxt == '0);
          ovf_d    = (a_msb_q != b_msb_q) && (sr_nxt[WIDTH-1] != a_msb_q);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_serial_subtractor;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 6;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(
    .WIDTH(W),
    .CW   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request keeps the unit busy for W+1 cycles,
  // the last of which is the done cycle carrying the arithmetic result.
  int         m_left   = 0;
  logic [W-1:0] m_pa   = '0;
  logic [W-1:0] m_pb   = '0;
  logic [W-1:0] m_diff = '0;
  logic       m_borrow = 1'b0;
  logic       m_zero   = 1'b0;
  logic       m_ovf    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = 0;
      m_diff   = '0;
      m_borrow = 1'b0;
      m_zero   = 1'b0;
      m_ovf    = 1'b0;
    end else if (m_left == 0) begin
      if (bus.start === 1'b1) begin
        m_pa   = bus.a;
        m_pb   = bus.b;
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        int sd;
        sd       = int'($signed(m_pa)) - int'($signed(m_pb));
        m_diff   = m_pa - m_pb;
        m_borrow = (m_pa < m_pb);
        m_zero   = (m_pa == m_pb);
        m_ovf    = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_left != 0));
    chk("done", 32'(bus.done), 32'(m_left == 1));
    chk("diff", 32'(bus.diff), 32'(m_diff));
    chk("borrow", 32'(bus.borrow), 32'(m_borrow));
    chk("zero", 32'(bus.zero), 32'(m_zero));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accepting edge; waits (bounded) for done and checks literals.
  task automatic wait_result(input string name, input logic [W-1:0] ed, input logic eb,
                             input logic ez, input logic eo);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    chk({name, "_latency"}, 32'(cycles), 32'(W));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    chk({name, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({name, "_borrow"}, 32'(bus.borrow), 32'(eb));
    chk({name, "_zero"}, 32'(bus.zero), 32'(ez));
    chk({name, "_overflow"}, 32'(bus.overflow), 32'(eo));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);  // operands are free to change after capture
    bus.b     = W'($urandom);
    wait_result(name, ed, eb, ez, eo);
    tick();  // DONE -> IDLE
  endtask

  initial begin
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    rst = 1'b0;
    tick();

    run_op("sub_100_37", 8'd100, 8'd37, 8'h3F, 1'b0, 1'b0, 1'b0);
    chk("model_pin_3f", 32'(m_diff), 32'h3F);
    run_op("sub_37_100", 8'd37, 8'd100, 8'hC1, 1'b1, 1'b0, 1'b0);
    chk("model_pin_c1_borrow", 32'(m_borrow), 32'd1);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    chk("model_pin_ovf", 32'(m_ovf), 32'd1);
    run_op("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
    run_op("sub_55_55", 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("model_pin_zero", 32'(m_zero), 32'd1);
    run_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op("sub_b_zero", 8'hA7, 8'h00, 8'hA7, 1'b0, 1'b0, 1'b0);

    // A start pulse during RUN must not disturb the operation in flight.
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd37;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    tick();
    bus.start = 1'b0;
    begin
      int cycles;
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < 40) begin
        tick();
        cycles++;
      end
      chk("ignored_start_latency", 32'(cycles), 32'(W - 4));
      chk("ignored_start_diff", 32'(bus.diff), 32'h3F);
      chk("ignored_start_zero", 32'(bus.zero), 32'd0);
    end
    tick();
    tick();
    chk("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Start held across DONE is accepted on the first IDLE edge.
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd37;
    tick();
    bus.a = 8'd200;
    bus.b = 8'd50;
    wait_result("held_first", 8'h3F, 1'b0, 1'b0, 1'b0);
    tick();  // DONE -> IDLE, start still high
    chk("held_idle_gap", 32'(bus.busy), 32'd0);
    tick();  // accepting edge
    bus.start = 1'b0;
    wait_result("held_second", 8'h96, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset in the middle of RUN aborts with no done pulse.
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd37;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_diff", 32'(bus.diff), 32'd0);
    chk("rst_mid_borrow", 32'(bus.borrow), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);
    run_op("after_rst", 8'd100, 8'd37, 8'h3F, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, including requests while busy and changing operands.
    ndone = 0;
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = W'($urandom);
      bus.b     = (i % 7 == 0) ? bus.a : W'($urandom);
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    bus.start = 1'b0;
    repeat (W + 3) tick();
    chk("rand_activity", 32'(ndone > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
